// File: rtl/drc_pkg.sv
// Shared DRC packet definitions: type codes and disassembler FSM states.
// Imported by both the inbound disassembler and the outbound assembler.
package drc_pkg;

    typedef enum logic [5:0] {
        PKT_NONE = 6'h00,
        UPRQ     = 6'h01,
        DNRQ     = 6'h02,
        UPRSP    = 6'h03,
        DNRSP    = 6'h04,
        RSHRP    = 6'h05,
        URCHRP   = 6'h06,
        RSHRQ    = 6'h07
    } pkt_type_e;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DECODE   = 3'd1,
        S_DISPATCH = 3'd2,
        S_UNRCH    = 3'd3,
        S_DROP     = 3'd4
    } dis_state_e;

    function automatic logic dst_hit(
        input logic [15:0] dst,
        input logic [15:0] local_addr,
        input logic [15:0] bcast
    );
        return (dst == local_addr) || (dst == bcast);
    endfunction

endpackage

// File: rtl/drc_sat_cnt.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
// Cleared only by the asynchronous reset.
module drc_sat_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         iClk,
    input  logic         iResetN,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge iClk or negedge iResetN) begin
        if (!iResetN) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/drc_pkt_dis.sv
// Inbound packet disassembler: accepts one packet, checks the destination,
// and dispatches it to upload/download/refresh consumers or raises unreachable.
module drc_pkt_dis
    import drc_pkg::*;
#(
    parameter int unsigned        TMO_W      = 8,
    parameter logic [TMO_W-1:0]   TMO_MAX    = 8'hFF,
    parameter logic [15:0]        BCAST_ADDR = 16'hFFFF
) (
    input  logic         iClk,
    input  logic         iResetN,
    input  logic         iPktVld,
    output logic         oPktRdy,
    input  logic [5:0]   iPktType,
    input  logic [15:0]  iPktSrcAddr,
    input  logic [15:0]  iPktDstAddr,
    input  logic [4:0]   iPktSrcPort,
    input  logic [127:0] iPktData,
    input  logic [15:0]  iLocalAddr,
    output logic         oUploadReqVld,
    input  logic         iUploadReqRdy,
    output logic         oDownloadReqVld,
    input  logic         iDownloadReqRdy,
    output logic         oRefreshRspVld,
    input  logic         iRefreshRspRdy,
    output logic [15:0]  oReqSrcAddr,
    output logic [4:0]   oReqSrcPort,
    output logic [127:0] oReqData,
    output logic         oUnreachableRspVld,
    output logic [15:0]  oUnreachableRspSrcAddr,
    output logic [4:0]   oUnreachableRspTargtPort,
    output logic [15:0]  oDropCnt
);

    dis_state_e       state;
    pkt_type_e        typ;
    logic [15:0]      src_addr;
    logic [15:0]      dst_addr;
    logic [4:0]       src_port;
    logic [127:0]     data;
    logic [TMO_W-1:0] tmo;
    logic             pkt_rdy;
    logic             up_vld;
    logic             dn_vld;
    logic             rs_vld;
    logic             unrch_vld;
    logic             sel_rdy;
    logic             drop_inc;

    // Rdy of a consumer only counts while its own Vld is raised.
    always_comb begin
        sel_rdy = (up_vld & iUploadReqRdy)
                | (dn_vld & iDownloadReqRdy)
                | (rs_vld & iRefreshRspRdy);
    end

    assign drop_inc = (state == S_DROP);

    always_ff @(posedge iClk or negedge iResetN) begin
        if (!iResetN) begin
            state     <= S_IDLE;
            typ       <= PKT_NONE;
            src_addr  <= '0;
            dst_addr  <= '0;
            src_port  <= '0;
            data      <= '0;
            tmo       <= '0;
            pkt_rdy   <= 1'b1;
            up_vld    <= 1'b0;
            dn_vld    <= 1'b0;
            rs_vld    <= 1'b0;
            unrch_vld <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (iPktVld && pkt_rdy) begin
                        typ      <= pkt_type_e'(iPktType);
                        src_addr <= iPktSrcAddr;
                        dst_addr <= iPktDstAddr;
                        src_port <= iPktSrcPort;
                        data     <= iPktData;
                        pkt_rdy  <= 1'b0;
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    tmo <= '0;
                    if (!dst_hit(dst_addr, iLocalAddr, BCAST_ADDR)) begin
                        unrch_vld <= 1'b1;
                        state     <= S_UNRCH;
                    end else begin
                        case (typ)
                            UPRQ: begin
                                up_vld <= 1'b1;
                                state  <= S_DISPATCH;
                            end
                            DNRQ: begin
                                dn_vld <= 1'b1;
                                state  <= S_DISPATCH;
                            end
                            RSHRP: begin
                                rs_vld <= 1'b1;
                                state  <= S_DISPATCH;
                            end
                            default: state <= S_DROP;
                        endcase
                    end
                end
                S_DISPATCH: begin
                    // A handshake on the final timeout cycle still wins.
                    if (sel_rdy) begin
                        up_vld  <= 1'b0;
                        dn_vld  <= 1'b0;
                        rs_vld  <= 1'b0;
                        pkt_rdy <= 1'b1;
                        state   <= S_IDLE;
                    end else if (tmo == TMO_MAX) begin
                        up_vld <= 1'b0;
                        dn_vld <= 1'b0;
                        rs_vld <= 1'b0;
                        state  <= S_DROP;
                    end else begin
                        tmo <= tmo + TMO_W'(1);
                    end
                end
                S_UNRCH: begin
                    unrch_vld <= 1'b0;
                    pkt_rdy   <= 1'b1;
                    state     <= S_IDLE;
                end
                S_DROP: begin
                    pkt_rdy <= 1'b1;
                    state   <= S_IDLE;
                end
                default: begin
                    up_vld    <= 1'b0;
                    dn_vld    <= 1'b0;
                    rs_vld    <= 1'b0;
                    unrch_vld <= 1'b0;
                    pkt_rdy   <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

    drc_sat_cnt #(
        .W(16)
    ) u_drop_cnt (
        .iClk    (iClk),
        .iResetN (iResetN),
        .inc     (drop_inc),
        .cnt     (oDropCnt)
    );

    assign oPktRdy                  = pkt_rdy;
    assign oUploadReqVld            = up_vld;
    assign oDownloadReqVld          = dn_vld;
    assign oRefreshRspVld           = rs_vld;
    assign oReqSrcAddr              = src_addr;
    assign oReqSrcPort              = src_port;
    assign oReqData                 = data;
    assign oUnreachableRspVld       = unrch_vld;
    assign oUnreachableRspSrcAddr   = src_addr;
    assign oUnreachableRspTargtPort = src_port;

endmodule
